dmem_bridge: RTL and testbench

DMEM_BRIDGE -- requirements
Module: dmem_bridge

---
 rtl/dmem_bridge.sv | 153 +++++++++++++++
 tb/tb_dmem_bridge.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bridge.sv
// Data-memory bridge: posts stores into a small write buffer and runs single
// bus transactions (buffered writes first, then loads) with a timeout watchdog.
//
//   state | meaning
//   IDLE  | no bus request; pick next write from buffer, else a pending load
//   WRITE | bus write of buffer head in flight
//   READ  | bus read for the stalled load in flight
//   RDONE | load data registered; load retires this cycle
module dmem_bridge #(
  parameter int TIMEOUT = 255,
  parameter int WBDEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic        sbM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        buserr,
  output logic        mreq,
  output logic        mwe,
  output logic [31:0] maddr,
  output logic [31:0] mwdata,
  output logic [3:0]  mbe,
  input  logic        mack,
  input  logic [31:0] mrdata
);

  localparam int PW = $clog2(WBDEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [PW:0]   WB_FULL  = (PW + 1)'(WBDEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] RDONE = 2'd3;

  logic [1:0]    state;
  logic [29:0]   wbAddr [WBDEPTH];
  logic [31:0]   wbData [WBDEPTH];
  logic [3:0]    wbBe   [WBDEPTH];
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;
  logic [PW:0]   wbCount;
  logic [CW-1:0] cycleCnt;
  logic          wbFull;
  logic          wbEmpty;
  logic          push;
  logic          pop;
  logic          ack;
  logic          expire;

  // Admission looks only at the registered count, so a same-cycle pop never frees a slot.
  assign wbFull  = (wbCount == WB_FULL);
  assign wbEmpty = (wbCount == '0);
  assign push    = memwriteM & ~memreadM & ~wbFull;
  assign ack     = mack & mreq;
  assign expire  = ~ack & (cycleCnt == CNT_LAST);
  assign pop     = (state == WRITE) & (ack | expire);
  assign stallM  = (memreadM & (state != RDONE)) | (memwriteM & wbFull);

  always_ff @(posedge clk) begin
    if (push) begin
      wbAddr[wrPtr] <= aluoutM[31:2];
      wbData[wrPtr] <= sbM ? {4{writedataM[7:0]}} : writedataM;
      wbBe[wrPtr]   <= sbM ? (4'b0001 << aluoutM[1:0]) : 4'b1111;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdPtr   <= '0;
      wrPtr   <= '0;
      wbCount <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   wbCount <= wbCount + 1'b1;
        2'b01:   wbCount <= wbCount - 1'b1;
        default: wbCount <= wbCount;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      readdataM <= '0;
      mreq      <= 1'b0;
      mwe       <= 1'b0;
      maddr     <= '0;
      mwdata    <= '0;
      mbe       <= '0;
      buserr    <= 1'b0;
      cycleCnt  <= '0;
    end else begin
      buserr <= 1'b0;
      case (state)
        IDLE: begin
          cycleCnt <= '0;
          if (!wbEmpty) begin
            state  <= WRITE;
            mreq   <= 1'b1;
            mwe    <= 1'b1;
            maddr  <= {wbAddr[rdPtr], 2'b00};
            mwdata <= wbData[rdPtr];
            mbe    <= wbBe[rdPtr];
          end else if (memreadM) begin
            // A simultaneous store is illegal: flag it once and service the load only.
            state  <= READ;
            mreq   <= 1'b1;
            mwe    <= 1'b0;
            mbe    <= 4'b1111;
            maddr  <= {aluoutM[31:2], 2'b00};
            buserr <= memwriteM;
          end
        end
        WRITE: begin
          if (ack || expire) begin
            state  <= IDLE;
            mreq   <= 1'b0;
            mwe    <= 1'b0;
            buserr <= expire;
          end else begin
            cycleCnt <= cycleCnt + 1'b1;
          end
        end
        READ: begin
          if (ack) begin
            state     <= RDONE;
            mreq      <= 1'b0;
            readdataM <= mrdata;
          end else if (expire) begin
            state     <= RDONE;
            mreq      <= 1'b0;
            readdataM <= 32'hDEAD_BEEF;
            buserr    <= 1'b1;
          end else begin
            cycleCnt <= cycleCnt + 1'b1;
          end
        end
        RDONE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: a bus slave model pops expected
// transactions from a scoreboard queue and checks them at each mack.
module tb_dmem_bridge;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } busTxn_t;

  logic        clk;
  logic        reset;
  logic        memreadM;
  logic        memwriteM;
  logic        sbM;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic [31:0] readdataM;
  logic        stallM;
  logic        buserr;
  logic        mreq;
  logic        mwe;
  logic [31:0] maddr;
  logic [31:0] mwdata;
  logic [3:0]  mbe;
  logic        mack;
  logic [31:0] mrdata;

  int errors = 0;
  int checks = 0;

  busTxn_t expQ[$];
  busTxn_t slvTxn;
  int      ackDelay = 2;
  bit      ackOff = 0;
  bit      lateAck = 0;
  int      waitCnt = 0;
  int      ackCount = 0;
  int      acceptAcks = 0;
  logic        capWe;
  logic [31:0] capAddr;
  logic [31:0] capData;
  logic [3:0]  capBe;

  dmem_bridge #(.TIMEOUT(8), .WBDEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .memreadM(memreadM), .memwriteM(memwriteM), .sbM(sbM),
    .aluoutM(aluoutM), .writedataM(writedataM),
    .readdataM(readdataM), .stallM(stallM), .buserr(buserr),
    .mreq(mreq), .mwe(mwe), .maddr(maddr), .mwdata(mwdata), .mbe(mbe),
    .mack(mack), .mrdata(mrdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus slave: acks ackDelay cycles after mreq is first seen and checks the scoreboard.
  initial begin
    mack = 1'b0;
    mrdata = '0;
    forever begin
      @(negedge clk);
      mack = lateAck;
      if (reset || !mreq || ackOff) begin
        waitCnt = 0;
      end else begin
        if (waitCnt == 0) begin
          capWe = mwe; capAddr = maddr; capData = mwdata; capBe = mbe;
          if (expQ.size() == 0) begin
            checks++; errors++;
            $display("FAIL busUnexpected: got we=%b addr=%h data=%h be=%b, required no transaction",
                     mwe, maddr, mwdata, mbe);
          end
        end
        if (waitCnt >= ackDelay) begin
          mack = 1'b1;
          ackCount++;
          waitCnt = 0;
          checks++;
          if ({mwe, maddr, mwdata, mbe} !== {capWe, capAddr, capData, capBe}) begin
            errors++;
            $display("FAIL busStable: at mack we=%b addr=%h data=%h be=%b, required held we=%b addr=%h data=%h be=%b",
                     mwe, maddr, mwdata, mbe, capWe, capAddr, capData, capBe);
          end
          if (expQ.size() > 0) begin
            slvTxn = expQ.pop_front();
            mrdata = slvTxn.data;
            checks++;
            if (mwe !== slvTxn.we || maddr !== slvTxn.addr || mbe !== slvTxn.be ||
                (slvTxn.we && mwdata !== slvTxn.data)) begin
              errors++;
              $display("FAIL busTxn: got we=%b addr=%h data=%h be=%b, required we=%b addr=%h data=%h be=%b",
                       mwe, maddr, mwdata, mbe, slvTxn.we, slvTxn.addr, slvTxn.data, slvTxn.be);
            end
          end
        end else begin
          waitCnt++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  task automatic pipeIdle();
    memreadM = 1'b0;
    memwriteM = 1'b0;
    sbM = 1'b0;
  endtask

  // Called at a negedge; holds the store until accepted, returns at the next negedge.
  task automatic doStore(input logic [31:0] a, input logic [31:0] d, input logic sb,
                         input logic [31:0] expAddr, input logic [31:0] expData,
                         input logic [3:0] expBe, output int stallCycles);
    busTxn_t t;
    memreadM = 1'b0; memwriteM = 1'b1; sbM = sb; aluoutM = a; writedataM = d;
    stallCycles = 0;
    #1;
    while (stallM && stallCycles < 100) begin
      @(negedge clk); #1;
      stallCycles++;
    end
    if (stallM) begin
      checks++; errors++;
      $display("FAIL storeAccept: stallM=%b after %0d cycles, required 0", stallM, stallCycles);
    end else begin
      t.we = 1'b1; t.addr = expAddr; t.data = expData; t.be = expBe;
      expQ.push_back(t);
      acceptAcks = ackCount;
    end
    @(negedge clk);
  endtask

  task automatic doLoad(input logic [31:0] a, input logic [31:0] rdata, input logic alsoWrite,
                        input logic [31:0] expRd, output int stallCycles, output int errPulses);
    busTxn_t t;
    t.we = 1'b0; t.addr = {a[31:2], 2'b00}; t.data = rdata; t.be = 4'b1111;
    expQ.push_back(t);
    memreadM = 1'b1; memwriteM = alsoWrite; aluoutM = a; writedataM = 32'h0F0F_0F0F;
    stallCycles = 0; errPulses = 0;
    #1;
    if (buserr) errPulses++;
    while (stallM && stallCycles < 100) begin
      @(negedge clk); #1;
      stallCycles++;
      if (buserr) errPulses++;
    end
    checks++;
    if (stallM !== 1'b0 || readdataM !== expRd) begin
      errors++;
      $display("FAIL loadData: stallM=%b readdataM=%h, required stallM=0 readdataM=%h", stallM, readdataM, expRd);
    end
    @(negedge clk);
    pipeIdle();
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    bit seen = 0;
    while ((expQ.size() != 0 || mreq) && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (expQ.size() != 0 || mreq) begin
      errors++;
      $display("FAIL %s drain: pending=%0d mreq=%b, required pending=0 mreq=0", name, expQ.size(), mreq);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (mreq) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL %s busIdle: mreq seen=1 after drain, required 0", name);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pipeIdle();
    aluoutM = '0; writedataM = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (mreq !== 1'b0) begin errors++; $display("FAIL rstMreq: got %b required 0", mreq); end
    checks++; if (mwe !== 1'b0) begin errors++; $display("FAIL rstMwe: got %b required 0", mwe); end
    checks++; if (maddr !== 32'h0) begin errors++; $display("FAIL rstMaddr: got %h required 0", maddr); end
    checks++; if (mwdata !== 32'h0) begin errors++; $display("FAIL rstMwdata: got %h required 0", mwdata); end
    checks++; if (mbe !== 4'h0) begin errors++; $display("FAIL rstMbe: got %b required 0000", mbe); end
    checks++; if (buserr !== 1'b0) begin errors++; $display("FAIL rstBuserr: got %b required 0", buserr); end
    checks++; if (readdataM !== 32'h0) begin errors++; $display("FAIL rstReaddata: got %h required 0", readdataM); end
    checks++; if (stallM !== 1'b0) begin errors++; $display("FAIL rstStall: got %b required 0", stallM); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word_store();
    int st;
    ackDelay = 3;
    doStore(32'h0000_0100, 32'h1234_5678, 1'b0, 32'h0000_0100, 32'h1234_5678, 4'b1111, st);
    pipeIdle();
    checks++;
    if (st !== 0) begin errors++; $display("FAIL wordStoreStall: got %0d stall cycles required 0", st); end
    waitDrain("wordStore");
  endtask

  task automatic test_byte_store();
    logic [31:0] addrT [4] = '{32'h0000_0203, 32'h0000_0201, 32'h0000_0200, 32'h0000_0307};
    logic [31:0] dataT [4] = '{32'h5555_55AB, 32'h0000_0017, 32'hFFFF_FF3C, 32'h89AB_CDEF};
    logic        sbT   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] eAddrT[4] = '{32'h0000_0200, 32'h0000_0200, 32'h0000_0200, 32'h0000_0304};
    logic [31:0] eDataT[4] = '{32'hABAB_ABAB, 32'h1717_1717, 32'h3C3C_3C3C, 32'h89AB_CDEF};
    logic [3:0]  eBeT  [4] = '{4'b1000, 4'b0010, 4'b0001, 4'b1111};
    int st;
    ackDelay = 1;
    for (int i = 0; i < 4; i++)
      doStore(addrT[i], dataT[i], sbT[i], eAddrT[i], eDataT[i], eBeT[i], st);
    pipeIdle();
    waitDrain("byteStore");
  endtask

  task automatic test_back_to_back();
    int st1, st2, st3, base;
    ackDelay = 1;
    ackOff = 1;
    base = ackCount;
    doStore(32'h0000_1000, 32'h1111_1111, 1'b0, 32'h0000_1000, 32'h1111_1111, 4'b1111, st1);
    doStore(32'h0000_1004, 32'h2222_2222, 1'b0, 32'h0000_1004, 32'h2222_2222, 4'b1111, st2);
    fork
      begin
        doStore(32'h0000_1008, 32'h3333_3333, 1'b0, 32'h0000_1008, 32'h3333_3333, 4'b1111, st3);
        pipeIdle();
      end
      begin
        repeat (2) @(negedge clk);
        #1 ackOff = 0;
      end
    join
    checks++; if (st1 !== 0) begin errors++; $display("FAIL b2bStall1: got %0d required 0", st1); end
    checks++; if (st2 !== 0) begin errors++; $display("FAIL b2bStall2: got %0d required 0", st2); end
    checks++; if (st3 < 1) begin errors++; $display("FAIL b2bStall3: got %0d stall cycles required >0", st3); end
    checks++;
    if (acceptAcks - base !== 1) begin
      errors++;
      $display("FAIL b2bRelease: third store accepted after %0d acks, required 1", acceptAcks - base);
    end
    waitDrain("backToBack");
  endtask

  task automatic test_store_then_load();
    int st, ls, ep;
    ackDelay = 2;
    doStore(32'h0000_0040, 32'h0BAD_F00D, 1'b0, 32'h0000_0040, 32'h0BAD_F00D, 4'b1111, st);
    doLoad(32'h0000_0040, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, ls, ep);
    checks++; if (ls < 1) begin errors++; $display("FAIL rawStall: got %0d stall cycles required >0", ls); end
    checks++; if (ep !== 0) begin errors++; $display("FAIL rawBuserr: got %0d pulses required 0", ep); end
    doStore(32'h0000_0044, 32'h4444_4444, 1'b0, 32'h0000_0044, 32'h4444_4444, 4'b1111, st);
    pipeIdle();
    waitDrain("storeLoad");
    checks++;
    if (readdataM !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL loadHold: got %h required cafef00d", readdataM);
    end
  endtask

  task automatic test_timeout();
    int tM = -1, tB = -1, tRel = -1, nb = 0;
    logic [31:0] rdAtB = '0;
    logic        mreqAtB = 1'b1;
    ackOff = 1;
    memreadM = 1'b1; memwriteM = 1'b0; aluoutM = 32'h0000_0080;
    for (int i = 0; i < 24; i++) begin
      #1;
      if (mreq && tM < 0) tM = i;
      if (buserr) begin
        nb++;
        if (tB < 0) begin tB = i; rdAtB = readdataM; mreqAtB = mreq; end
      end
      if (!stallM && memreadM && tRel < 0) tRel = i;
      @(negedge clk);
      if (tRel >= 0) memreadM = 1'b0;
    end
    ackOff = 0;
    checks++; if (tB - tM !== 8) begin errors++; $display("FAIL toGap: buserr %0d cycles after mreq, required 8", tB - tM); end
    checks++; if (nb !== 1) begin errors++; $display("FAIL toPulse: buserr high %0d cycles, required 1", nb); end
    checks++; if (rdAtB !== 32'hDEAD_BEEF) begin errors++; $display("FAIL toData: got %h required deadbeef", rdAtB); end
    checks++; if (mreqAtB !== 1'b0) begin errors++; $display("FAIL toMreq: got %b required 0", mreqAtB); end
    checks++; if (tRel !== tB) begin errors++; $display("FAIL toRelease: stall released at %0d, required %0d", tRel, tB); end
  endtask

  task automatic test_illegal();
    int ls, ep;
    ackDelay = 1;
    doLoad(32'h0000_02C0, 32'h600D_D00D, 1'b1, 32'h600D_D00D, ls, ep);
    checks++; if (ep !== 1) begin errors++; $display("FAIL illegalBuserr: got %0d pulses required 1", ep); end
    waitDrain("illegal");
  endtask

  task automatic test_reset_mid();
    int st, n;
    bit bad;
    ackOff = 1;
    doStore(32'h0000_0600, 32'h6666_0000, 1'b0, 32'h0000_0600, 32'h6666_0000, 4'b1111, st);
    doStore(32'h0000_0604, 32'h6666_0004, 1'b0, 32'h0000_0604, 32'h6666_0004, 4'b1111, st);
    pipeIdle();
    n = 0;
    #1;
    while (!mreq && n < 20) begin @(negedge clk); #1; n++; end
    checks++; if (mreq !== 1'b1) begin errors++; $display("FAIL rmidWrite: mreq=%b required 1", mreq); end
    reset = 1'b1;
    #1;
    checks++; if (mreq !== 1'b0) begin errors++; $display("FAIL rmidMreq: got %b required 0", mreq); end
    checks++;
    if ({mwe, maddr, mwdata, mbe} !== '0) begin
      errors++;
      $display("FAIL rmidBus: mwe=%b addr=%h data=%h be=%b required all 0", mwe, maddr, mwdata, mbe);
    end
    expQ.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1 lateAck = 1'b1; mrdata = 32'h1357_9BDF;
    @(negedge clk);
    #1 lateAck = 1'b0;
    ackOff = 0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (mreq || buserr || readdataM !== 32'h0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL lateAck: mreq=%b buserr=%b readdataM=%h, required 0 0 00000000", mreq, buserr, readdataM);
    end
    @(negedge clk);
    ackDelay = 1;
    doStore(32'h0000_0700, 32'h7777_7777, 1'b0, 32'h0000_0700, 32'h7777_7777, 4'b1111, st);
    pipeIdle();
    checks++; if (st !== 0) begin errors++; $display("FAIL rmidStall: got %0d required 0", st); end
    waitDrain("resetMid");
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_byte_store();
    test_back_to_back();
    test_store_then_load();
    test_timeout();
    test_illegal();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
